data_mem_mmio: RTL and testbench

//  Parametrised data-memory/MMIO slave for the 16-bit CPU. It replaces the single-cycle DataMemory.

---
 rtl/data_mem_mmio_pkg.sv | 25 ++
 rtl/data_mem_mmio_decode.sv | 59 +++++
 rtl/data_mem_mmio.sv | 209 ++++++++++++++++++++
 tb/tb_data_mem_mmio.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_mmio_pkg.sv
// Shared types and constants for the data-memory / MMIO slave.
package data_mem_mmio_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_SECOND = 2'd2
    } state_t;

    localparam logic ACC_BYTE = 1'b0;
    localparam logic ACC_HALF = 1'b1;

    localparam logic [15:0] DEF_RAM_BASE   = 16'h1000;
    localparam logic [15:0] DEF_LED_BASE   = 16'h2000;
    localparam logic [15:0] DEF_DIGIT_BASE = 16'h3000;

    // Bit positions in the one-hot region vector; all-zero means unmapped.
    localparam int RG_ROM = 0;
    localparam int RG_RAM = 1;
    localparam int RG_LED = 2;
    localparam int RG_DIG = 3;

    typedef logic [3:0] region_t;

endpackage

// File: rtl/data_mem_mmio_decode.sv
// Combinational address decoder: region one-hot, region-relative offset,
// odd-halfword RAM detection and address-level faults.
module mmio_addr_decode
    import data_mem_mmio_pkg::*;
#(
    parameter int          RAM_BYTES  = 64,
    parameter int          NUM_LEDS   = 4,
    parameter int          NUM_DIGITS = 6,
    parameter logic [15:0] RAM_BASE   = DEF_RAM_BASE,
    parameter logic [15:0] LED_BASE   = DEF_LED_BASE,
    parameter logic [15:0] DIGIT_BASE = DEF_DIGIT_BASE
) (
    input  logic [15:0] DAddress,
    input  logic        memc,
    output region_t     region,
    output logic [15:0] offset,
    output logic        misaligned,
    output logic        fault
);

    logic [15:0] ram_off;
    logic [15:0] led_off;
    logic [15:0] dig_off;

    always_comb begin
        ram_off    = DAddress - RAM_BASE;
        led_off    = DAddress - LED_BASE;
        dig_off    = DAddress - DIGIT_BASE;
        region     = '0;
        offset     = '0;
        misaligned = 1'b0;
        fault      = 1'b0;
        if (DAddress < RAM_BASE) begin
            region[RG_ROM] = 1'b1;
            offset         = DAddress;
        end else if (ram_off < 16'(RAM_BYTES)) begin
            region[RG_RAM] = 1'b1;
            offset         = ram_off;
            if (memc == ACC_HALF) begin
                // the last byte has no partner inside the window
                if (ram_off == 16'(RAM_BYTES - 1))
                    fault = 1'b1;
                else
                    misaligned = ram_off[0];
            end
        end else if (led_off < 16'(NUM_LEDS)) begin
            region[RG_LED] = 1'b1;
            offset         = led_off;
        end else if (dig_off < 16'(NUM_DIGITS)) begin
            region[RG_DIG] = 1'b1;
            offset         = dig_off;
            if (memc == ACC_HALF && dig_off == 16'(NUM_DIGITS - 1))
                fault = 1'b1;
        end else begin
            fault = 1'b1;
        end
    end

endmodule

// File: rtl/data_mem_mmio.sv
// Data-memory / MMIO slave: req/ready handshake, byte RAM with reset clear
// sweep, LED and 7-seg digit registers, ROM data window.
module data_mem_mmio
    import data_mem_mmio_pkg::*;
#(
    parameter int          RAM_BYTES  = 64,
    parameter int          NUM_LEDS   = 4,
    parameter int          NUM_DIGITS = 6,
    parameter logic [15:0] RAM_BASE   = DEF_RAM_BASE,
    parameter logic [15:0] LED_BASE   = DEF_LED_BASE,
    parameter logic [15:0] DIGIT_BASE = DEF_DIGIT_BASE
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    req,
    input  logic                    wmem,
    input  logic                    memc,
    input  logic [15:0]             DAddress,
    input  logic [15:0]             DataIn,
    input  logic [15:0]             DataFromROM,
    output logic [15:0]             ROMDataAddress,
    output logic                    ready,
    output logic [15:0]             DataOut,
    output logic                    err,
    output logic [NUM_LEDS-1:0]     led,
    output logic [8*NUM_DIGITS-1:0] digit_flat
);

    localparam int AW = (RAM_BYTES  > 1) ? $clog2(RAM_BYTES)  : 1;
    localparam int LW = (NUM_LEDS   > 1) ? $clog2(NUM_LEDS)   : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_t state, state_nx;

    logic [7:0]                  ram [RAM_BYTES];
    logic [NUM_DIGITS-1:0][7:0]  digit_r;
    logic [AW-1:0]               clr_ptr;
    logic [AW-1:0]               sec_idx;
    logic [7:0]                  sec_lo;
    logic [7:0]                  sec_hi;
    logic                        sec_wr;

    region_t     dec_region;
    logic [15:0] dec_off;
    logic        dec_mis;
    logic        dec_fault;

    logic          accept;
    logic          fault_any;
    logic          wr_ok;
    logic [AW-1:0] idx, idx1;
    logic [LW-1:0] led_k;
    logic [DW-1:0] dig_k, dig_k1;
    logic [15:0]   rd_data;

    logic          wa_en, wb_en;
    logic [AW-1:0] wa_idx, wb_idx;
    logic [7:0]    wa_dat, wb_dat;

    logic unused_off;
    assign unused_off = ^dec_off;

    assign ROMDataAddress = DAddress;
    assign digit_flat     = digit_r;

    mmio_addr_decode #(
        .RAM_BYTES  (RAM_BYTES),
        .NUM_LEDS   (NUM_LEDS),
        .NUM_DIGITS (NUM_DIGITS),
        .RAM_BASE   (RAM_BASE),
        .LED_BASE   (LED_BASE),
        .DIGIT_BASE (DIGIT_BASE)
    ) u_dec (
        .DAddress   (DAddress),
        .memc       (memc),
        .region     (dec_region),
        .offset     (dec_off),
        .misaligned (dec_mis),
        .fault      (dec_fault)
    );

    assign idx       = dec_off[AW-1:0];
    assign idx1      = idx + AW'(1);
    assign led_k     = dec_off[LW-1:0];
    assign dig_k     = dec_off[DW-1:0];
    assign dig_k1    = dig_k + DW'(1);
    assign fault_any = dec_fault || (dec_region[RG_ROM] && wmem);
    assign wr_ok     = accept && wmem && !fault_any;

    always_comb begin
        rd_data = '0;
        if (dec_region[RG_ROM])
            rd_data = DataFromROM;
        else if (dec_region[RG_RAM])
            rd_data = (memc == ACC_HALF) ? {ram[idx1], ram[idx]} : {8'h00, ram[idx]};
        else if (dec_region[RG_LED])
            rd_data = {15'h0000, led[led_k]};
        else if (dec_region[RG_DIG])
            rd_data = (memc == ACC_HALF) ? {digit_r[dig_k1], digit_r[dig_k]} : {8'h00, digit_r[dig_k]};
    end

    always_ff @(posedge CLK) begin
        if (!RESET)
            state <= ST_CLEAR;
        else
            state <= state_nx;
    end

    // A still-high ready blocks acceptance, so a held req can't re-trigger.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            ST_CLEAR:  if (clr_ptr == AW'(RAM_BYTES - 2)) state_nx = ST_IDLE;
            ST_IDLE: begin
                if (req && !ready) begin
                    accept = 1'b1;
                    if (dec_mis) state_nx = ST_SECOND;
                end
            end
            ST_SECOND: state_nx = ST_IDLE;
            default:   state_nx = ST_CLEAR;
        endcase
    end

    // Two RAM write ports: the sweep clears a byte pair, aligned halfwords
    // write both bytes, an odd halfword writes its high byte in SECOND.
    always_comb begin
        wa_en  = 1'b0;
        wa_idx = idx;
        wa_dat = DataIn[7:0];
        wb_en  = 1'b0;
        wb_idx = idx1;
        wb_dat = DataIn[15:8];
        case (state)
            ST_CLEAR: begin
                wa_en  = 1'b1;
                wa_idx = clr_ptr;
                wa_dat = 8'h00;
                wb_en  = 1'b1;
                wb_idx = clr_ptr + AW'(1);
                wb_dat = 8'h00;
            end
            ST_IDLE: begin
                if (wr_ok && dec_region[RG_RAM]) begin
                    wa_en = 1'b1;
                    wb_en = (memc == ACC_HALF) && !dec_mis;
                end
            end
            ST_SECOND: begin
                if (sec_wr) begin
                    wa_en  = 1'b1;
                    wa_idx = sec_idx;
                    wa_dat = sec_hi;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            if (wa_en) ram[wa_idx] <= wa_dat;
            if (wb_en) ram[wb_idx] <= wb_dat;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            ready   <= 1'b0;
            err     <= 1'b0;
            DataOut <= '0;
            led     <= '0;
            digit_r <= '0;
            clr_ptr <= '0;
            sec_idx <= '0;
            sec_lo  <= '0;
            sec_hi  <= '0;
            sec_wr  <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            if (state == ST_CLEAR)
                clr_ptr <= clr_ptr + AW'(2);
            if (accept && dec_mis) begin
                sec_idx <= idx1;
                sec_lo  <= ram[idx];
                sec_hi  <= DataIn[15:8];
                sec_wr  <= wmem;
            end else if (accept) begin
                ready <= 1'b1;
                err   <= fault_any;
                if (!wmem)
                    DataOut <= fault_any ? 16'h0000 : rd_data;
                if (wr_ok && dec_region[RG_LED])
                    led[led_k] <= DataIn[0];
                if (wr_ok && dec_region[RG_DIG]) begin
                    digit_r[dig_k] <= DataIn[7:0];
                    if (memc == ACC_HALF) digit_r[dig_k1] <= DataIn[15:8];
                end
            end
            if (state == ST_SECOND) begin
                ready <= 1'b1;
                if (!sec_wr) DataOut <= {ram[sec_idx], sec_lo};
            end
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Randomized bench for data_mem_mmio against an address-map reference model.
module tb_data_mem_mmio;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req, wmem, memc;
    logic [15:0] DAddress, DataIn, DataFromROM, ROMDataAddress, DataOut;
    logic        ready, err;
    logic [3:0]  led;
    logic [47:0] digit_flat;

    logic [15:0] rom_val;
    logic [7:0]  mram [64];
    logic [3:0]  mled;
    logic [7:0]  mdig [6];
    int          errs   = 0;
    int          checks = 0;

    assign DataFromROM = rom_val;

    always #5 CLK = ~CLK;

    data_mem_mmio dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .req            (req),
        .wmem           (wmem),
        .memc           (memc),
        .DAddress       (DAddress),
        .DataIn         (DataIn),
        .DataFromROM    (DataFromROM),
        .ROMDataAddress (ROMDataAddress),
        .ready          (ready),
        .DataOut        (DataOut),
        .err            (err),
        .led            (led),
        .digit_flat     (digit_flat)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mram[i] = 8'h00;
        for (int i = 0; i < 6; i++)  mdig[i] = 8'h00;
        mled = 4'h0;
    endtask

    function automatic logic [47:0] exp_digits();
        logic [47:0] v;
        for (int k = 0; k < 6; k++) v[8*k +: 8] = mdig[k];
        return v;
    endfunction

    task automatic model(input logic wr, input logic half, input logic [15:0] a, input logic [15:0] d,
                         output logic [15:0] edo, output logic ee, output int elat);
        int off;
        edo  = 16'h0000;
        ee   = 1'b0;
        elat = 1;
        if (a < 16'h1000) begin
            if (wr) ee = 1'b1;
            else    edo = rom_val;
        end else if (a < 16'h1040) begin
            off = int'(a) - 'h1000;
            if (half && off == 63) ee = 1'b1;
            else begin
                if (half && (off % 2) == 1) elat = 2;
                if (wr) begin
                    mram[off] = d[7:0];
                    if (half) mram[off+1] = d[15:8];
                end else
                    edo = half ? {mram[off+1], mram[off]} : {8'h00, mram[off]};
            end
        end else if (a >= 16'h2000 && a < 16'h2004) begin
            off = int'(a) - 'h2000;
            if (wr) mled[off] = d[0];
            else    edo = {15'h0000, mled[off]};
        end else if (a >= 16'h3000 && a < 16'h3006) begin
            off = int'(a) - 'h3000;
            if (half && off == 5) ee = 1'b1;
            else if (wr) begin
                mdig[off] = d[7:0];
                if (half) mdig[off+1] = d[15:8];
            end else
                edo = half ? {mdig[off+1], mdig[off]} : {8'h00, mdig[off]};
        end else begin
            ee = 1'b1;
        end
    endtask

    task automatic do_acc(input logic wr, input logic half, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] dout, output logic e, output int lat);
        @(posedge CLK); #1;
        wmem = wr; memc = half; DAddress = a; DataIn = d; req = 1'b1;
        lat = 0;
        chk("rom_addr", ROMDataAddress, a);
        while (lat < 8) begin
            @(posedge CLK); #1;
            lat++;
            if (ready) break;
        end
        req  = 1'b0;
        dout = DataOut;
        e    = err;
    endtask

    task automatic access(input logic wr, input logic half, input logic [15:0] a, input logic [15:0] d);
        logic [15:0] edo, gdo;
        logic        ee, ge;
        int          el, gl;
        model(wr, half, a, d, edo, ee, el);
        do_acc(wr, half, a, d, gdo, ge, gl);
        chk($sformatf("lat@%h", a), 64'(gl), 64'(el));
        chk($sformatf("err@%h", a), ge, ee);
        if (!wr) chk($sformatf("rdata@%h", a), gdo, edo);
        chk($sformatf("led@%h", a), led, mled);
        chk($sformatf("digits@%h", a), digit_flat, exp_digits());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        int          hits, n;
        RESET = 1'b0; req = 1'b1; wmem = 1'b0; memc = 1'b0;
        DAddress = 16'h103E; DataIn = 16'h0000; rom_val = 16'hA5A5;
        model_reset();

        @(posedge CLK); #1;
        chk("rst_ready", ready, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_dout", DataOut, 16'h0000);
        chk("rst_led", led, 4'h0);
        chk("rst_digits", digit_flat, 48'h0);
        RESET = 1'b1;
        hits = 0;
        for (int i = 0; i < 32; i++) begin
            @(posedge CLK); #1;
            if (ready) hits++;
        end
        chk("clear_ready", 64'(hits), 64'd0);
        @(posedge CLK); #1;
        chk("first_ready", ready, 1'b1);
        chk("clear_rd", DataOut, 16'h0000);
        chk("clear_err", err, 1'b0);
        req = 1'b0;

        access(1, 1, 16'h1004, 16'hBEEF);
        access(0, 0, 16'h1004, 16'h0000);
        access(0, 0, 16'h1005, 16'h0000);
        access(1, 1, 16'h1007, 16'h1234);
        access(0, 0, 16'h1007, 16'h0000);
        access(0, 0, 16'h1008, 16'h0000);
        access(0, 1, 16'h1007, 16'h0000);
        access(1, 1, 16'h103F, 16'hFFFF);
        access(0, 0, 16'h103F, 16'h0000);
        access(1, 0, 16'h2002, 16'h0001);
        access(0, 0, 16'h2002, 16'h0000);
        access(0, 1, 16'h2004, 16'h0000);
        access(1, 1, 16'h3000, 16'h0605);
        access(1, 1, 16'h3005, 16'hABCD);
        access(0, 0, 16'h3005, 16'h0000);
        access(0, 1, 16'h0100, 16'h0000);
        access(1, 1, 16'h0100, 16'h5555);
        access(0, 1, 16'h1800, 16'h0000);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 6))
                0:       a = 16'($urandom_range(0, 'h0FFF));
                1, 2:    a = 16'h1000 + 16'($urandom_range(0, 63));
                3:       a = 16'h2000 + 16'($urandom_range(0, 5));
                4:       a = 16'h3000 + 16'($urandom_range(0, 7));
                5:       a = 16'h1040 + 16'($urandom_range(0, 'h0FBF));
                default: a = 16'h4000 + 16'($urandom_range(0, 'hBFFF));
            endcase
            rom_val = 16'($urandom);
            access(1'($urandom), 1'($urandom), a, 16'($urandom));
        end

        // reset while an odd halfword write sits in its second cycle
        @(posedge CLK); #1;
        wmem = 1'b1; memc = 1'b1; DAddress = 16'h1009; DataIn = 16'h5AA5; req = 1'b1;
        @(posedge CLK); #1;
        chk("sec_pending", ready, 1'b0);
        RESET = 1'b0; wmem = 1'b0; DAddress = 16'h1008;
        @(posedge CLK); #1;
        chk("sec_abort_rdy", ready, 1'b0);
        RESET = 1'b1;
        model_reset();
        n = 0;
        while (n < 64) begin
            @(posedge CLK); #1;
            n++;
            if (ready) break;
        end
        req = 1'b0;
        chk("sec_clear_lat", 64'(n), 64'd33);
        chk("sec_clear_rd", DataOut, 16'h0000);
        chk("sec_clear_led", led, 4'h0);
        access(0, 0, 16'h1009, 16'h0000);
        access(0, 1, 16'h1004, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
